// File: rtl/yt_oci_dct_pkg.sv
// Shared types and constants for the OCI data-capture-trace (DCT) sequencer.
// Frame geometry, the sequencer state enum and the atom packing helper.
package yt_oci_dct_pkg;

   localparam int ATOM_W  = 2;
   localparam int ATOMS   = 15;
   localparam int CNT_W   = 4;
   localparam int FRAME_W = ATOM_W * ATOMS;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ATOMS);

   typedef enum logic [1:0] {
      FILL,
      STALL,
      DRAIN,
      ENDED
   } dct_state_e;

   // Place an atom in the slot just above the atoms already packed.
   function automatic logic [FRAME_W-1:0] pack_atom(
      input logic [FRAME_W-1:0] frame_v,
      input logic [CNT_W-1:0]   cnt_v,
      input logic [ATOM_W-1:0]  atom_v
   );
      logic [FRAME_W-1:0] ext;
      ext = FRAME_W'(atom_v);
      return frame_v | (ext << (cnt_v * ATOM_W));
   endfunction

endpackage

// File: rtl/yt_oci_dct_frame_slot.sv
// One-entry valid/ready holding register for finished DCT frames.
// Ports: clk/reset; load_i, data_i, count_i in; ready_i from consumer;
//        valid_o, data_o, count_o out.
module yt_oci_dct_frame_slot
   import yt_oci_dct_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic [FRAME_W-1:0] data_i,
   input  logic [CNT_W-1:0]   count_i,
   input  logic               ready_i,
   output logic               valid_o,
   output logic [FRAME_W-1:0] data_o,
   output logic [CNT_W-1:0]   count_o
);

   logic               valid_q;
   logic [FRAME_W-1:0] data_q;
   logic [CNT_W-1:0]   count_q;

   // A load wins over a take, so a drain plus load in one cycle leaves no bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         count_q <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         count_q <= count_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign count_o = count_q;

endmodule

// File: rtl/yt_system_nios_oci_dct_ctrl.sv
// DCT sequencer: packs 2-bit trace atoms into 30-bit frames, handles flush
// and end-of-test drain. Ports: clk, reset; atom_valid/atom_data/atom_ready;
// flush_req, test_ending; frame_valid/data/count, frame_ready;
// dct_buffer, dct_count; test_has_ended, late_atom.
module yt_system_nios_oci_dct_ctrl
   import yt_oci_dct_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               atom_valid,
   input  logic [ATOM_W-1:0]  atom_data,
   output logic               atom_ready,
   input  logic               flush_req,
   input  logic               test_ending,
   output logic               frame_valid,
   output logic [FRAME_W-1:0] frame_data,
   output logic [CNT_W-1:0]   frame_count,
   input  logic               frame_ready,
   output logic [FRAME_W-1:0] dct_buffer,
   output logic [CNT_W-1:0]   dct_count,
   output logic               test_has_ended,
   output logic               late_atom
);

   dct_state_e         state_q, state_d;
   logic [FRAME_W-1:0] buf_q, buf_d, pk_buf;
   logic [CNT_W-1:0]   cnt_q, cnt_d, pk_cnt;
   logic               end_q, end_d;
   logic               late_q, late_d;
   logic               ended_q;
   logic               rdy_q;
   logic               accept;
   logic               slot_free;
   logic               load;
   logic               trigger;

   assign slot_free = !frame_valid | frame_ready;
   assign accept    = atom_valid & rdy_q;

   always_comb begin
      pk_buf  = accept ? pack_atom(buf_q, cnt_q, atom_data) : buf_q;
      pk_cnt  = cnt_q + CNT_W'(accept);
      trigger = (pk_cnt == FULL_CNT) | (flush_req & (pk_cnt != '0));
      state_d = state_q;
      buf_d   = pk_buf;
      cnt_d   = pk_cnt;
      end_d   = end_q;
      late_d  = late_q;
      load    = 1'b0;
      unique case (state_q)
         FILL: begin
            if (trigger && slot_free) begin
               load    = 1'b1;
               buf_d   = '0;
               cnt_d   = '0;
               state_d = test_ending ? DRAIN : FILL;
            end else if (trigger) begin
               state_d = STALL;
               end_d   = test_ending;
            end else if (test_ending) begin
               state_d = DRAIN;
            end
         end
         STALL: begin
            end_d = end_q | test_ending;
            if (slot_free) begin
               load    = 1'b1;
               buf_d   = '0;
               cnt_d   = '0;
               state_d = end_d ? DRAIN : FILL;
            end
         end
         DRAIN: begin
            if (cnt_q != '0) begin
               if (slot_free) begin
                  load  = 1'b1;
                  buf_d = '0;
                  cnt_d = '0;
               end
            end else if (!frame_valid) begin
               state_d = ENDED;
            end
         end
         ENDED: begin
            late_d = late_q | atom_valid;
         end
         default: state_d = FILL;
      endcase
   end

   // atom_ready is registered from the next state so it reads 0 in reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FILL;
         buf_q   <= '0;
         cnt_q   <= '0;
         end_q   <= 1'b0;
         late_q  <= 1'b0;
         ended_q <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         end_q   <= end_d;
         late_q  <= late_d;
         ended_q <= (state_d == ENDED);
         rdy_q   <= (state_d == FILL);
      end
   end

   yt_oci_dct_frame_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load),
      .data_i  (pk_buf),
      .count_i (pk_cnt),
      .ready_i (frame_ready),
      .valid_o (frame_valid),
      .data_o  (frame_data),
      .count_o (frame_count)
   );

   assign atom_ready     = rdy_q;
   assign dct_buffer     = buf_q;
   assign dct_count      = cnt_q;
   assign test_has_ended = ended_q;
   assign late_atom      = late_q;

endmodule
